fetch_sequencer: RTL

- Multi-cycle fetch/decode/control FSM that sits directly upstream of the program counter.
- Reads the current PC and fetches the instruction word from memory over a req/ready handshake, then latches it into the instruction register.
- Resolves control flow (sequential, JMP, JZ, HALT) and drives the PC's pc_enable, select and bus inputs.
- Non-control-flow instructions are handed to the datapath via an exec_start/exec_done handshake.

---
 rtl/fetch_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch/decode/control sequencer sitting in front of the program counter.
// Fetches over a req/ready handshake, resolves control flow and hands other ops to the datapath.
module fetch_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [3:0]  OPC_JMP     = 4'hC,
  parameter logic [3:0]  OPC_JZ      = 4'hD,
  parameter logic [3:0]  OPC_HALT    = 4'hF,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_req,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             zero_flag,
  output logic             exec_start,
  input  logic             exec_done,
  output logic [WIDTH-1:0] ir,
  output logic             pc_enable,
  output logic             select,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_drive,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [2:0] {
    StFetch,
    StWaitMem,
    StDecode,
    StExec,
    StPcUpdate,
    StHalt,
    StFault
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             exec_start_q, exec_start_d;
  logic             pc_enable_q, pc_enable_d;
  logic             select_q, select_d;
  logic             bus_drive_q, bus_drive_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  logic [3:0]       opcode;
  logic [WIDTH-1:0] jump_target;
  logic [7:0]       cnt_inc;
  logic             take_jump;

  assign opcode    = ir_q[WIDTH-1 -: 4];
  assign cnt_inc   = cnt_q + 8'd1;
  assign take_jump = (opcode == OPC_JMP) || ((opcode == OPC_JZ) && zero_flag);

  // Jump targets only carry a 12-bit field; upper bits are forced to zero.
  always_comb begin
    jump_target       = '0;
    jump_target[11:0] = ir_q[11:0];
  end

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    ir_d         = ir_q;
    bus_out_d    = bus_out_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    exec_start_d = 1'b0;
    pc_enable_d  = 1'b0;
    select_d     = select_q;
    bus_drive_d  = bus_drive_q;
    halted_d     = halted_q;
    fault_d      = fault_q;

    case (state_q)
      StFetch: begin
        mem_addr_d = pc;
        mem_req_d  = 1'b1;
        cnt_d      = 8'd0;
        state_d    = StWaitMem;
      end

      StWaitMem: begin
        if (mem_ready) begin
          ir_d      = mem_rdata;
          mem_req_d = 1'b0;
          state_d   = StDecode;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TimeoutCnt) begin
            mem_req_d = 1'b0;
            halted_d  = 1'b1;
            fault_d   = 1'b1;
            state_d   = StFault;
          end
        end
      end

      StDecode: begin
        if (opcode == OPC_HALT) begin
          halted_d = 1'b1;
          state_d  = StHalt;
        end else if (take_jump) begin
          bus_out_d   = jump_target;
          select_d    = 1'b1;
          bus_drive_d = 1'b1;
          pc_enable_d = 1'b1;
          state_d     = StPcUpdate;
        end else if (opcode == OPC_JZ) begin
          select_d    = 1'b0;
          bus_drive_d = 1'b0;
          pc_enable_d = 1'b1;
          state_d     = StPcUpdate;
        end else begin
          exec_start_d = 1'b1;
          state_d      = StExec;
        end
      end

      StExec: begin
        if (exec_done) begin
          select_d    = 1'b0;
          bus_drive_d = 1'b0;
          pc_enable_d = 1'b1;
          state_d     = StPcUpdate;
        end
      end

      // pc_enable was raised on entry, so it is high for exactly this cycle.
      StPcUpdate: begin
        select_d    = 1'b0;
        bus_drive_d = 1'b0;
        state_d     = StFetch;
      end

      StHalt: begin
        halted_d = 1'b1;
      end

      StFault: begin
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end

      default: begin
        mem_req_d = 1'b0;
        halted_d  = 1'b1;
        fault_d   = 1'b1;
        state_d   = StFault;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StFetch;
      mem_addr_q   <= '0;
      ir_q         <= '0;
      bus_out_q    <= '0;
      cnt_q        <= 8'd0;
      mem_req_q    <= 1'b0;
      exec_start_q <= 1'b0;
      pc_enable_q  <= 1'b0;
      select_q     <= 1'b0;
      bus_drive_q  <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      ir_q         <= ir_d;
      bus_out_q    <= bus_out_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      exec_start_q <= exec_start_d;
      pc_enable_q  <= pc_enable_d;
      select_q     <= select_d;
      bus_drive_q  <= bus_drive_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_req    = mem_req_q;
  assign exec_start = exec_start_q;
  assign ir         = ir_q;
  assign pc_enable  = pc_enable_q;
  assign select     = select_q;
  assign bus_out    = bus_out_q;
  assign bus_drive  = bus_drive_q;
  assign halted     = halted_q;
  assign fault      = fault_q;

endmodule
